mem_wb_skid_stage: RTL and testbench

//   Parametrised MEM->WB pipeline stage with valid/ready handshake and a 2-entry

---
 rtl/mem_wb_skid_stage.sv | 139 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// rtl/mem_wb_skid_stage.sv - MEM->WB pipeline stage with valid/ready handshake and 2-entry skid buffer
module mem_wb_skid_stage #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter bit ZERO_RD = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_memtoreg,
    input  logic            in_regwrite,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_memtoreg,
    output logic            out_regwrite,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rdata,
    output logic [XLEN-1:0] out_wb_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_next;

    logic acc, pop;
    logic head_load, head_from_skid, skid_load;

    logic            head_memtoreg, skid_memtoreg;
    logic            head_regwrite, skid_regwrite;
    logic [RA_W-1:0] head_rd, skid_rd;
    logic [XLEN-1:0] head_result, skid_result;
    logic [XLEN-1:0] head_rdata, skid_rdata;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        head_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        head_load = 1'b1;
                    end else if (acc) begin
                        skid_load  = 1'b1;
                        state_next = TWO;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_from_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_memtoreg <= 1'b0;
            head_regwrite <= 1'b0;
            head_rd       <= '0;
            head_result   <= '0;
            head_rdata    <= '0;
        end else if (head_from_skid) begin
            head_memtoreg <= skid_memtoreg;
            head_regwrite <= skid_regwrite;
            head_rd       <= skid_rd;
            head_result   <= skid_result;
            head_rdata    <= skid_rdata;
        end else if (head_load) begin
            head_memtoreg <= in_memtoreg;
            head_regwrite <= in_regwrite;
            head_rd       <= in_rd;
            head_result   <= in_result;
            head_rdata    <= in_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_memtoreg <= 1'b0;
            skid_regwrite <= 1'b0;
            skid_rd       <= '0;
            skid_result   <= '0;
            skid_rdata    <= '0;
        end else if (skid_load) begin
            skid_memtoreg <= in_memtoreg;
            skid_regwrite <= in_regwrite;
            skid_rd       <= in_rd;
            skid_result   <= in_result;
            skid_rdata    <= in_rdata;
        end
    end

    assign out_memtoreg = head_memtoreg;
    assign out_rd       = head_rd;
    assign out_result   = head_result;
    assign out_rdata    = head_rdata;
    assign out_wb_data  = head_memtoreg ? head_rdata : head_result;
    assign out_regwrite = out_valid & head_regwrite & ~(ZERO_RD & (head_rd == '0));

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb/tb_mem_wb_skid_stage.sv - randomized bench for mem_wb_skid_stage against a 2-deep FIFO model
module tb_mem_wb_skid_stage;

    typedef struct {
        logic        m;
        logic        w;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] dat;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_memtoreg, in_regwrite;
    logic [4:0]  in_rd;
    logic [63:0] in_result, in_rdata;

    logic        in_ready, out_valid, out_memtoreg, out_regwrite;
    logic [4:0]  out_rd;
    logic [63:0] out_result, out_rdata, out_wb_data;

    logic        nz_in_ready, nz_out_valid, nz_out_memtoreg, nz_out_regwrite;
    logic [4:0]  nz_out_rd;
    logic [63:0] nz_out_result, nz_out_rdata, nz_out_wb_data;

    int checks = 0;
    int failures = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.XLEN(64), .RA_W(5), .ZERO_RD(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_rd(in_rd),
        .in_result(in_result), .in_rdata(in_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite), .out_rd(out_rd),
        .out_result(out_result), .out_rdata(out_rdata), .out_wb_data(out_wb_data)
    );

    mem_wb_skid_stage #(.XLEN(64), .RA_W(5), .ZERO_RD(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(nz_in_ready),
        .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_rd(in_rd),
        .in_result(in_result), .in_rdata(in_rdata),
        .out_valid(nz_out_valid), .out_ready(out_ready),
        .out_memtoreg(nz_out_memtoreg), .out_regwrite(nz_out_regwrite), .out_rd(nz_out_rd),
        .out_result(nz_out_result), .out_rdata(nz_out_rdata), .out_wb_data(nz_out_wb_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.m   = 1'($urandom_range(0, 1));
        e.w   = 1'($urandom_range(0, 1));
        e.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        e.res = {$urandom, $urandom};
        e.dat = {$urandom, $urandom};
        return e;
    endfunction

    function automatic ent_t mk(input logic m, input logic w, input logic [4:0] rd,
                                input logic [63:0] res, input logic [63:0] dat);
        ent_t e;
        e.m = m; e.w = w; e.rd = rd; e.res = res; e.dat = dat;
        return e;
    endfunction

    // Compare both DUTs against the model's queue occupancy and head entry.
    task automatic check_outputs();
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        check("nz_out_valid", {63'd0, nz_out_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("out_memtoreg", {63'd0, out_memtoreg}, {63'd0, q[0].m});
            check("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
            check("out_result", out_result, q[0].res);
            check("out_rdata", out_rdata, q[0].dat);
            check("out_wb_data", out_wb_data, q[0].m ? q[0].dat : q[0].res);
            check("out_regwrite", {63'd0, out_regwrite}, {63'd0, q[0].w && (q[0].rd != 5'd0)});
            check("nz_out_regwrite", {63'd0, nz_out_regwrite}, {63'd0, q[0].w});
        end else begin
            check("out_regwrite_idle", {63'd0, out_regwrite}, 64'd0);
            check("nz_out_regwrite_idle", {63'd0, nz_out_regwrite}, 64'd0);
        end
    endtask

    // Called at a negedge: check, drive one cycle of stimulus, advance model, return at next negedge.
    task automatic step(input logic iv, input logic ordy, input logic fl, input ent_t e);
        logic acc, pop;
        check_outputs();
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        in_memtoreg = e.m;
        in_regwrite = e.w;
        in_rd       = e.rd;
        in_result   = e.res;
        in_rdata    = e.dat;
        acc = iv && (q.size() < 2);
        pop = ordy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_memtoreg = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_result = '0; in_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_rdata", out_rdata, 64'd0);
        check("rst_out_wb_data", out_wb_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Streaming at full rate, alternating ALU and load entries.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 1'b0, mk(1'(i % 2), 1'b1, 5'(i + 1), 64'h100 + 64'(i), 64'hDEAD_BEEF));
        repeat (2) step(1'b0, 1'b1, 1'b0, rand_ent());

        // Back-pressure: A and B fill the stage, C must wait.
        step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 5'd10, 64'hA, 64'h0));
        step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 5'd11, 64'hB, 64'h0));
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 5'd12, 64'hC, 64'hC0C0));
        repeat (4) step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 5'd12, 64'hC, 64'hC0C0));
        repeat (2) step(1'b0, 1'b1, 1'b0, rand_ent());

        // Flush while full with a valid input presented.
        step(1'b1, 1'b0, 1'b0, rand_ent());
        step(1'b1, 1'b0, 1'b0, rand_ent());
        step(1'b1, 1'b1, 1'b1, rand_ent());
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);

        // x0 write suppression on ZERO_RD=1 only.
        step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 5'd0, 64'h55, 64'h66));
        check("x0_suppressed", {63'd0, out_regwrite}, 64'd0);
        check("x0_not_suppressed", {63'd0, nz_out_regwrite}, 64'd1);
        step(1'b0, 1'b1, 1'b0, rand_ent());

        // Asynchronous reset in mid-cycle while holding entries.
        step(1'b1, 1'b0, 1'b0, rand_ent());
        step(1'b1, 1'b0, 1'b0, rand_ent());
        #2 reset = 1'b1;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_out_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("async_rst_wb_data", out_wb_data, 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), rand_ent());
        repeat (3) step(1'b0, 1'b1, 1'b0, rand_ent());
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
